// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and default latencies.
package mdu_pkg;

  localparam logic [3:0] MD_OP_NONE  = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_MULTU = 4'd2;
  localparam logic [3:0] MD_OP_DIV   = 4'd3;
  localparam logic [3:0] MD_OP_DIVU  = 4'd4;
  localparam logic [3:0] MD_OP_MTHI  = 4'd5;
  localparam logic [3:0] MD_OP_MTLO  = 4'd6;
  localparam logic [3:0] MD_OP_MFHI  = 4'd7;
  localparam logic [3:0] MD_OP_MFLO  = 4'd8;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for the latched MD operation; wr_en is
// low when the result must not be committed (divide by zero, non-arith ops).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        wr_en
);

  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // Sign-magnitude division; 0x80000000 / -1 yields magnitude 0x80000000,
  // whose negation wraps back to 0x80000000 with remainder 0.
  always_comb begin
    prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u     = {32'd0, a} * {32'd0, b};
    div_signed = (op == MD_OP_DIV);
    a_neg      = div_signed & a[31];
    b_neg      = div_signed & b[31];
    a_mag      = a_neg ? (32'd0 - a) : a;
    b_mag      = b_neg ? (32'd0 - b) : b;
    div_zero   = (b == 32'd0);
    b_safe     = div_zero ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quo        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem        = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Select the result for the operation class
  always_comb begin
    hi_res = 32'd0;
    lo_res = 32'd0;
    wr_en  = 1'b0;
    case (op)
      MD_OP_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
        wr_en  = 1'b1;
      end
      MD_OP_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
        wr_en  = 1'b1;
      end
      MD_OP_DIV, MD_OP_DIVU: begin
        hi_res = rem;
        lo_res = quo;
        wr_en  = ~div_zero;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_controller.sv
// Multiply/divide sequencer for the E stage: fixed-latency busy window, HI/LO
// registers, move-to handling and the D-stage stall request.
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_req,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      rs_q, rs_d, rt_q, rt_d, hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_res, lo_res;
  logic             wr_en;

  mdu_arith u_arith (
    .op     (op_q),
    .a      (rs_q),
    .b      (rt_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .wr_en  (wr_en)
  );

  // Next-state logic; a start while busy is deliberately ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
              state_d = ST_BUSY;
              busy_d  = 1'b1;
              op_d    = md_op;
              rs_d    = rs_val;
              rt_d    = rt_val;
              cnt_d   = ((md_op == MD_OP_MULT) || (md_op == MD_OP_MULTU))
                        ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end
            MD_OP_MTHI: hi_d = rs_val;
            MD_OP_MTLO: lo_d = rs_val;
            default:    state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (wr_en) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any in-flight operation without a commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_OP_NONE;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign md_busy  = busy_q;
  assign md_stall = md_req & (md_start | busy_q);
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mdu_controller.sv
// Scoreboard bench for mdu_controller: directed cases plus random ops checked
// against a plain-arithmetic HI/LO model.
module tb_mdu_controller;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, md_start, md_req;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_busy, md_stall;
  logic [31:0] hi_out, lo_out;

  mdu_controller #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_req   (md_req),
    .md_busy  (md_busy),
    .md_stall (md_stall),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    logic [3:0]  op;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi, m_lo;
  int          bcnt = 0;
  logic        prev_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: updates m_hi/m_lo, reports whether the op is multi-cycle
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic is_long, output int cyc);
    longint      ps, q, r;
    logic [63:0] pu;
    is_long = 1'b0;
    cyc     = 0;
    case (op)
      MD_OP_MULT: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        m_hi = ps[63:32]; m_lo = ps[31:0];
        is_long = 1'b1; cyc = MC;
      end
      MD_OP_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32]; m_lo = pu[31:0];
        is_long = 1'b1; cyc = MC;
      end
      MD_OP_DIV: begin
        if (b != 32'd0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        is_long = 1'b1; cyc = DC;
      end
      MD_OP_DIVU: begin
        if (b != 32'd0) begin
          m_lo = a / b; m_hi = a % b;
        end
        is_long = 1'b1; cyc = DC;
      end
      MD_OP_MTHI: m_hi = a;
      MD_OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    logic is_long;
    int   cyc, guard;
    md_start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_req = req;
    model_op(op, a, b, is_long, cyc);
    if (is_long) sb.push_back('{m_hi, m_lo, cyc, op});
    tick;
    md_start = 1'b0;
    md_op    = 4'($urandom_range(0, 8));
    rs_val   = $urandom;
    rt_val   = $urandom;
    if (is_long) begin
      guard = 0;
      while (md_busy && guard < DC + 5) begin
        tick;
        rs_val = $urandom;
        rt_val = $urandom;
        guard++;
      end
      if (md_busy) chk("busy_timeout", 64'(md_busy), 64'd0);
    end else begin
      chk("short_hi", 64'(hi_out), 64'(m_hi));
      chk("short_lo", 64'(lo_out), 64'(m_lo));
      chk("short_busy", 64'(md_busy), 64'd0);
    end
  endtask

  // Monitor: compares each commit when md_busy falls, including busy length
  always @(negedge clk) begin
    if (reset) begin
      bcnt      = 0;
      prev_busy = 1'b0;
    end else begin
      if (md_busy) begin
        bcnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_commit: got hi=%h lo=%h expected none", hi_out, lo_out);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("commit_hi op%0d", mon_e.op), 64'(hi_out), 64'(mon_e.hi));
          chk($sformatf("commit_lo op%0d", mon_e.op), 64'(lo_out), 64'(mon_e.lo));
          chk($sformatf("busy_len op%0d", mon_e.op), 64'(bcnt), 64'(mon_e.cycles));
        end
        bcnt = 0;
      end
      prev_busy = md_busy;
    end
  end

  // Protocol check: a start must never arrive while an op is in flight
  always @(posedge clk) begin
    assert (reset || !(md_start && md_busy))
      else $error("FAIL protocol: md_start while md_busy");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; md_start = 1'b0; md_op = MD_OP_NONE;
    rs_val = 32'd0; rt_val = 32'd0; md_req = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) tick;
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_stall", 64'(md_stall), 64'd0);
    reset = 1'b0; md_req = 1'b0;
    tick;

    issue(MD_OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 64'(lo_out), 64'h0000_0000_FFFF_FFFA);
    issue(MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("multu_hi", 64'(hi_out), 64'h0000_0000_0000_0002);
    chk("multu_lo", 64'(lo_out), 64'h0000_0000_FFFF_FFFA);
    issue(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_hi", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
    chk("div_lo", 64'(lo_out), 64'h0000_0000_FFFF_FFFD);
    issue(MD_OP_DIVU,  32'd7, 32'd0, 1'b0);
    chk("div0_hi", 64'(hi_out), 64'h0000_0000_FFFF_FFFF);
    chk("div0_lo", 64'(lo_out), 64'h0000_0000_FFFF_FFFD);

    // Stall window: start cycle plus exactly MC busy cycles
    begin
      logic il;
      int   cy;
      md_req = 1'b1; md_start = 1'b1; md_op = MD_OP_MULT;
      rs_val = 32'h10; rt_val = 32'h20;
      #1 chk("stall_start", 64'(md_stall), 64'd1);
      model_op(MD_OP_MULT, 32'h10, 32'h20, il, cy);
      sb.push_back('{m_hi, m_lo, cy, MD_OP_MULT});
      tick;
      md_start = 1'b0;
      for (int i = 0; i < MC; i++) begin
        chk($sformatf("stall_busy%0d", i), 64'(md_stall), 64'd1);
        tick;
      end
      chk("stall_after", 64'(md_stall), 64'd0);
      chk("busy_after", 64'(md_busy), 64'd0);
      md_req = 1'b0;
    end

    issue(MD_OP_MTHI, 32'h0000_1234, 32'd0, 1'b0);
    chk("mthi", 64'(hi_out), 64'h0000_0000_0000_1234);
    issue(MD_OP_MTLO, 32'hCAFE_0001, 32'd0, 1'b0);
    issue(MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf_hi", 64'(hi_out), 64'd0);
    chk("ovf_lo", 64'(lo_out), 64'h0000_0000_8000_0000);
    issue(MD_OP_MULT, 32'h0001_0003, 32'h0002_0005, 1'b0);

    // Reset in the 4th busy cycle of a DIV: abort, no later commit
    md_start = 1'b1; md_op = MD_OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    tick;
    md_start = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    sb.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort_busy", 64'(md_busy), 64'd0);
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_lo", 64'(lo_out), 64'd0);
    repeat (DC + 2) tick;
    chk("abort_late_hi", 64'(hi_out), 64'd0);
    chk("abort_late_lo", 64'(lo_out), 64'd0);
    chk("abort_late_busy", 64'(md_busy), 64'd0);

    for (int k = 0; k < 60; k++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 8));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      issue(op, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) tick;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
- Sequences the multi-cycle multiply/divide unit (HI/LO) attached to the E stage of the five-stage MIPS pipeline.
- Accepts one MD operation per issue, holds the unit busy for a fixed latency, then commits the result to HI/LO.
- Produces the stall request the hazard unit uses to freeze the D stage when an MD-class instruction would collide with an in-flight operation.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- md_start  input  1  E-stage instruction is an MD op this cycle (already stall-qualified)
- md_op  input  4  operation code (package encoding)
- rs_val  input  32  forwarded rs operand (E stage)
- rt_val  input  32  forwarded rt operand (E stage)
- md_req  input  1  D-stage instruction is MD-class (any of mult..mflo)
- md_busy  output  1  operation in flight
- md_stall  output  1  stall request to hazard unit
- hi_out  output  32  current HI
- lo_out  output  32  current LO

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: HI=0, LO=0, md_busy=0, counter=0, state IDLE. A reset mid-operation aborts it with no HI/LO commit.
- States:
  - IDLE: no operation in flight.
  - BUSY: counter counts down; result is committed when it expires.
- IDLE, md_start with op in {MULT, MULTU, DIV, DIVU}:
  - Latch rs_val, rt_val and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY. md_busy rises the following cycle.
- BUSY:
  - Counter decrements each cycle.
  - On the cycle the counter equals 1, the edge that ends it writes HI/LO and returns to IDLE.
  - md_busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). The new HI/LO is visible on the cycle md_busy falls.
- IDLE, md_start with MTHI/MTLO: write rs_val to HI/LO at that edge; no busy.
- MFHI/MFLO/NONE: no state change; readers use hi_out/lo_out combinationally.
- md_start while BUSY is a protocol violation, prevented by md_stall. The controller ignores it; the bench flags it with an assertion.
- md_stall = md_req & (md_start | md_busy). This covers back-to-back MD instructions in D and E.
- Arithmetic:
  - MULT: signed 32x32 -> 64. HI = [63:32], LO = [31:0].
  - MULTU: the same, unsigned.
  - DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend (signed) or unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (either signedness): busy for full DIV_CYCLES, HI/LO unchanged.
- Operands are captured at start. Later changes to rs_val/rt_val have no effect.

Decomposition:
- Shared package mdu_pkg:
  - MD_OP_* codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - State encoding IDLE/BUSY.
  - Default latency constants.
- Sub-module mdu_arith: purely combinational. Takes latched operands and op, produces hi_res/lo_res, and owns the div-by-zero and overflow cases. mdu_controller owns the FSM, counter, HI/LO registers and stall.

Test Plan:
- Signed MULT: start MULT rs=0xFFFFFFFE (-2), rt=3 -> md_busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, same operands: rs=0xFFFFFFFE, rt=3 -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- Signed DIV: DIV rs=0xFFFFFFF9 (-7), rt=2 -> 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 7/0 -> HI/LO unchanged after 10 busy cycles.
- Stall and move-to: MULT issued, md_req held high -> md_stall high for start cycle plus 5 busy cycles, low after. MTHI rs=0x1234 while IDLE -> hi_out=0x1234 next cycle, md_busy stays 0.
- Reset abort and overflow:
  - DIV started, reset asserted in 4th busy cycle -> next cycle md_busy=0, HI=LO=0, no later commit.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
